// File: rtl/one_to_eight_demux_reg.sv
// ----------------------------------------------------------------------------
// one_to_eight_demux_reg
//
// Registered 1-to-8 write-side demultiplexer. One WIDTH-bit input word is
// steered to the lane picked by i_sel and held there until that lane's
// consumer acknowledges it. Write/distribute counterpart of eight_to_one_mux.
//
// Handshake semantics:
//   Input side : a word transfers on a rising edge where i_in_valid=1 and
//                o_in_ready=1. o_in_ready is combinational, depends only on
//                the held lane state, i_sel and i_out_ack (never i_in_valid),
//                and the source need not hold i_d/i_sel while stalled.
//   Output side: lane i offers data while o_out_valid[i]=1; the consumer
//                takes it on an edge with i_out_ack[i]=1. Acks on empty
//                lanes are ignored.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_d          input data word (WIDTH)
//   i_sel        destination lane 0..7
//   i_in_valid   i_d/i_sel valid this cycle
//   o_in_ready   lane i_sel can accept this cycle (combinational)
//   o_y          lane i data at o_y[i*WIDTH +: WIDTH] (registered)
//   o_out_valid  per-lane unconsumed-data flags (registered)
//   i_out_ack    per-lane consumer acknowledge
//   o_occupied   number of full lanes, 0..8 (registered)
//   o_stall_cnt  saturating count of cycles with valid & ~ready (registered)
// ----------------------------------------------------------------------------
module one_to_eight_demux_reg #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [WIDTH-1:0]       i_d,
    input  logic [2:0]             i_sel,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [8*WIDTH-1:0]     o_y,
    output logic [7:0]             o_out_valid,
    input  logic [7:0]             i_out_ack,
    output logic [3:0]             o_occupied,
    output logic [CNT_WIDTH-1:0]   o_stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] STALL_MAX = '1;

    logic [8*WIDTH-1:0]   r_y;
    logic [7:0]           r_valid;
    logic [3:0]           r_occupied;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic                 w_ready;
    logic                 w_stall;
    logic [7:0]           w_wr;
    logic [7:0]           w_valid_next;
    logic [3:0]           w_occ_next;

    // A full lane can still accept when its consumer drains it this cycle,
    // which gives one word per cycle per lane back-to-back.
    assign w_ready = ~r_valid[i_sel] | i_out_ack[i_sel];
    assign w_stall = i_in_valid & ~w_ready;

    always_comb begin
        w_wr = 8'h00;
        if (i_in_valid && w_ready) begin
            w_wr[i_sel] = 1'b1;
        end
    end

    // Ack clears a lane, but a write to the same lane in the same cycle wins.
    assign w_valid_next = (r_valid & ~i_out_ack) | w_wr;

    // Occupancy is registered from the next-state flags so it always tracks
    // o_out_valid exactly.
    always_comb begin
        w_occ_next = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_occ_next = w_occ_next + {3'd0, w_valid_next[i]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid    <= 8'h00;
            r_occupied <= 4'd0;
        end else begin
            r_valid    <= w_valid_next;
            r_occupied <= w_occ_next;
        end
    end

    // Lane data is only ever changed by a write; acks leave it in place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_y <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (w_wr[i]) begin
                    r_y[i*WIDTH +: WIDTH] <= i_d;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_in_ready  = w_ready;
    assign o_y         = r_y;
    assign o_out_valid = r_valid;
    assign o_occupied  = r_occupied;
    assign o_stall_cnt = r_stall_cnt;

endmodule
